// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU that processes DIGIT bits per cycle, LSB first, with valid/ready on both sides.
// Build macro ALU_SHIFT_EN turns code 111 into a bit-serial sll; otherwise 111 returns result=0, zero=1.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALU_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SAFE_DIGIT = (DIGIT < 1) ? 1 : DIGIT;
  localparam int N          = WIDTH / SAFE_DIGIT;
  localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`ifdef ALU_SHIFT_EN
  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  generate
    if ((DIGIT < 1) || ((WIDTH % SAFE_DIGIT) != 0)) begin : g_bad_param
      $error("alu_serial: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
`ifdef ALU_SHIFT_EN
  logic [SH_W-1:0]  sh_q, sh_d;
`endif

  logic [DIGIT-1:0] a_dig_s, b_dig_s, b_eff_s, dig_res_s;
  logic [DIGIT:0]   sum_s;
  logic             use_sub_s, lt_s;
  logic [WIDTH-1:0] acc_full_s, final_s;

  // Slice datapath: one DIGIT-wide add/sub or bitwise op on the low digit of the shifting operands.
  always_comb begin
    a_dig_s   = a_q[DIGIT-1:0];
    b_dig_s   = b_q[DIGIT-1:0];
    use_sub_s = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
    b_eff_s   = use_sub_s ? ~b_dig_s : b_dig_s;
    sum_s     = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: dig_res_s = sum_s[DIGIT-1:0];
      OP_AND:  dig_res_s = a_dig_s & b_dig_s;
      OP_OR:   dig_res_s = a_dig_s | b_dig_s;
      OP_XOR:  dig_res_s = a_dig_s ^ b_dig_s;
      OP_SLL:  dig_res_s = {DIGIT{1'b0}};
      default: dig_res_s = {DIGIT{1'b0}};
    endcase
    // New digit enters at the top so the LSB digit ends up at bit 0 after N slices.
    acc_full_s = (acc_q >> DIGIT) | (WIDTH'(dig_res_s) << (WIDTH - DIGIT));
    case (op_q)
      OP_SLT:  lt_s = (a_dig_s[DIGIT-1] != b_dig_s[DIGIT-1]) ? a_dig_s[DIGIT-1] : sum_s[DIGIT-1];
      OP_SLTU: lt_s = ~sum_s[DIGIT];
      default: lt_s = 1'b0;
    endcase
    case (op_q)
      OP_SLT, OP_SLTU: final_s = WIDTH'(lt_s);
      OP_SLL:          final_s = {WIDTH{1'b0}};
      default:         final_s = acc_full_s;
    endcase
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and all datapath registers.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
`ifdef ALU_SHIFT_EN
    sh_d        = sh_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = S_RUN;
          op_d       = ALU_control;
          a_d        = src_a;
          b_d        = src_b;
          acc_d      = {WIDTH{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          carry_d    = (ALU_control == OP_SUB) || (ALU_control == OP_SLT) || (ALU_control == OP_SLTU);
          in_ready_d = 1'b0;
`ifdef ALU_SHIFT_EN
          sh_d       = src_b[SH_W-1:0];
`endif
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_RUN: begin
`ifdef ALU_SHIFT_EN
        if (op_q == OP_SLL) begin
          if (sh_q == {SH_W{1'b0}}) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = a_q;
            zero_d      = (a_q == {WIDTH{1'b0}});
          end else begin
            a_d  = a_q << 1'b1;
            sh_d = sh_q - SH_W'(1);
          end
        end else
`endif
        begin
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          acc_d   = acc_full_s;
          carry_d = sum_s[DIGIT];
          if (cnt_q == LAST) begin
            state_d     = S_DONE;
            cnt_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b1;
            result_d    = final_s;
            zero_d      = (final_s == {WIDTH{1'b0}});
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
`ifdef ALU_SHIFT_EN
      sh_q        <= {SH_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
`ifdef ALU_SHIFT_EN
      sh_q        <= sh_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=32, DIGIT=8): directed vectors plus a cycle-level
// transaction model compared on every falling edge.
module tb_alu_serial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ALU_control = 3'b000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_control(ALU_control), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      default: return a << b[4:0];
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_SHIFT_EN
    if (op == 3'd7) return int'(b[4:0]) + 1;
`endif
    return 4;
  endfunction

  // Transaction model: accept, count down latency, present result until consumed.
  logic        m_busy = 1'b0, m_in_ready = 1'b1, m_ov = 1'b0, m_zero = 1'b0;
  logic [31:0] m_res = 32'd0, m_pend = 32'd0;
  int          m_left = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_in_ready <= 1'b1; m_ov <= 1'b0;
      m_res <= 32'd0; m_zero <= 1'b0; m_left <= 0;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov <= 1'b0;
        m_in_ready <= 1'b1;
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_ov <= 1'b1; m_res <= m_pend; m_zero <= (m_pend == 32'd0);
      end else begin
        m_left <= m_left - 1;
      end
    end else if (in_valid && m_in_ready) begin
      m_busy <= 1'b1; m_in_ready <= 1'b0;
      m_left <= model_lat(ALU_control, src_b);
      m_pend <= model_res(ALU_control, src_a, src_b);
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("cmp in_ready", 32'(in_ready), 32'(m_in_ready));
      check("cmp out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("cmp result", result, m_res);
        check("cmp zero", 32'(zero), 32'(m_zero));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clock); #1; guard++;
    end
    check("in_ready wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; ALU_control = op; src_a = a; src_b = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    ALU_control = 3'($urandom_range(7, 0)); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    check("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_out(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp_res);
    check({name, " zero"}, 32'(zero), 32'(exp_zero));
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("add 5+7", 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 4);
    run_op("add wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 4);
    run_op("sub borrow", 3'd1, 32'h0000_0100, 32'd1, 32'h0000_00FF, 1'b0, 4);
    run_op("sub 3-3", 3'd1, 32'd3, 32'd3, 32'd0, 1'b1, 4);
    run_op("slt -1<1", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 4);
    run_op("sltu", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 4);
    run_op("slt 5<-2", 3'd5, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b1, 4);
    run_op("sltu 5<big", 3'd6, 32'd5, 32'hFFFF_FFFE, 32'd1, 1'b0, 4);
    run_op("and", 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 4);
    run_op("or", 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 4);
    run_op("xor", 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 4);
`ifdef ALU_SHIFT_EN
    run_op("sll 1<<4", 3'd7, 32'd1, 32'd4, 32'd16, 1'b0, 5);
    run_op("sll by 0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 1);
`else
    run_op("code 111", 3'd7, 32'd1, 32'd4, 32'd0, 1'b1, 4);
`endif

    // Backpressure with a competing request held during DONE.
    issue(3'd0, 32'd10, 32'd20);
    wait_out(lat);
    in_valid = 1'b1; ALU_control = 3'd0; src_a = 32'd2; src_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp result", result, 32'd30);
      check("bp zero", 32'(zero), 32'd0);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("post-handshake out_valid", 32'(out_valid), 32'd0);
    check("post-handshake in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("held op accepted", 32'(in_ready), 32'd0);
    wait_out(lat);
    check("held op latency", 32'(lat), 32'd4);
    check("held op result", result, 32'd4);
    consume();

    // Reset pulse in RUN with cnt=2.
    issue(3'd0, 32'h1111_1111, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #2;
    check("mid-run reset out_valid", 32'(out_valid), 32'd0);
    check("mid-run reset result", result, 32'd0);
    check("mid-run reset in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("no stale output", 32'(out_valid), 32'd0);
    run_op("add 1+1 after reset", 3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 4);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
